// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths and responder state encoding
package cpu_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with byte-lane synchronous write and combinational read
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [BE_W-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Only enabled lanes are written; contents are never cleared
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < BE_W; i++)
                if (be[i])
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency req/ack memory responder with error decode
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              bad;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     raddr;
    logic [WORD_W-1:0] mem_rd;
    logic              to_resp;
    logic              sel_we;
    logic              sel_bad;
    logic              wr_en;

    // Address decode and the next-cycle response path; in IDLE the live inputs
    // are used so a LATENCY=1 response can be formed before capture lands
    always_comb begin
        bad     = (addr[1:0] != 2'b00) || ({2'b00, addr} >= (34'(DEPTH) << 2));
        idx     = addr[AW+1:2];
        to_resp = (state == IDLE && req && LATENCY == 1) || (state == WAIT && cnt == 4'd0);
        raddr   = (state == IDLE) ? idx : idx_q;
        sel_we  = (state == IDLE) ? we : we_q;
        sel_bad = (state == IDLE) ? bad : err_q;
        wr_en   = (state == RESP) && we_q && !err_q && !reset;
    end

    // Transaction FSM, latency counter, capture registers and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
            rdata <= '0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                idx_q   <= idx;
                wdata_q <= wdata;
                be_q    <= be;
                err_q   <= bad;
                cnt     <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
                state   <= (LATENCY == 1) ? RESP : WAIT;
            end else if (state == WAIT) begin
                cnt   <= cnt - 4'd1;
                state <= (cnt == 4'd0) ? RESP : WAIT;
            end else if (state == RESP) begin
                state <= IDLE;
            end
            if (to_resp)
                rdata <= sel_bad ? '0 : sel_we ? rdata : mem_rd;
        end
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);
    assign err  = ack && err_q;

    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .be    (be_q),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (raddr),
        .rdata (mem_rd)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench over three latencies against a word-array model
module tb_data_mem_responder;

    typedef struct packed {
        logic        e;
        logic [31:0] d;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rs    [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic        ack   [3];
    logic        busy  [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    int          lat [3] = '{2, 1, 4};
    exp_t        sb [3][$];
    logic [31:0] ref_mem [3][256];
    logic [31:0] last  [3];
    logic [31:0] shown [3];
    exp_t        mx;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : du
        data_mem_responder #(.DEPTH(256), .LATENCY(g == 0 ? 2 : g == 1 ? 1 : 4)) dut (
            .clk   (clk),
            .reset (rs[g]),
            .req   (req[g]),
            .we    (we[g]),
            .addr  (addr[g]),
            .wdata (wdata[g]),
            .be    (be[g]),
            .ack   (ack[g]),
            .rdata (rdata[g]),
            .busy  (busy[g]),
            .err   (err[g])
        );
    end

    task automatic chk(string n, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", n, k, act, exp, cyc);
        end
    endtask

    // Reference: memory as a word array, error for misaligned or out-of-range,
    // rdata cleared on error, unchanged on writes, ack LATENCY cycles after accept.
    task automatic model(int k, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b, int c);
        exp_t        x;
        logic [31:0] word;
        int          ix;
        bit          bad;
        bad = (a % 4 != 0) || (a >= 32'd1024);
        ix  = int'(a / 4);
        if (bad) begin
            x.e = 1'b1;
            x.d = '0;
        end else begin
            x.e = 1'b0;
            if (w) begin
                word = ref_mem[k][ix];
                for (int i = 0; i < 4; i++)
                    if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                ref_mem[k][ix] = word;
                x.d = last[k];
            end else begin
                x.d = ref_mem[k][ix];
            end
        end
        last[k] = x.d;
        x.c     = c;
        sb[k].push_back(x);
    endtask

    task automatic drain(int k, bit tog);
        bit done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            #1;
            if (sb[k].size() == 0)
                done = 1'b1;
            else if (tog) begin
                we[k]    = 1'($urandom);
                addr[k]  = $urandom;
                wdata[k] = $urandom;
                be[k]    = 4'($urandom);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ack_timeout dut%0d: got no ack, required ack within 40 cycles", k);
            sb[k].delete();
        end
    endtask

    // Accept happens at the next rising edge (cyc+1); ack is seen in the cycle
    // that ends at edge accept+LATENCY, i.e. while cyc == accept+LATENCY-1.
    task automatic issue(int k, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b, bit tog);
        @(negedge clk);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        be[k]    = b;
        model(k, w, a, d, b, cyc + lat[k]);
        drain(k, tog);
        req[k] = 1'b0;
    endtask

    task automatic b2b(logic [31:0] a0, logic [31:0] a1, logic [31:0] a2);
        int          acc;
        int          l;
        bit          fin = 1'b0;
        logic [31:0] aa [3];
        l     = lat[0];
        aa[0] = a0;
        aa[1] = a1;
        aa[2] = a2;
        @(negedge clk);
        req[0]   = 1'b1;
        we[0]    = 1'b0;
        addr[0]  = a0;
        wdata[0] = $urandom;
        be[0]    = 4'hF;
        acc      = cyc + 1;
        for (int j = 0; j < 3; j++)
            model(0, 1'b0, aa[j], 32'd0, 4'd0, acc + j * (l + 1) + l - 1);
        for (int n = 0; n < 3 * (l + 1) + 2 && !fin; n++) begin
            @(negedge clk);
            #1;
            chk("b2b_busy", 0, 32'(busy[0]), (cyc == acc + l || cyc == acc + 2 * l + 1) ? 32'd0 : 32'd1);
            if (cyc == acc + l - 1) addr[0] = a1;
            if (cyc == acc + 2 * l) addr[0] = a2;
            if (cyc == acc + 3 * l + 1) fin = 1'b1;
        end
        req[0] = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL b2b_timeout dut0: got no third ack, required one by cycle %0d", acc + 3 * l + 1);
        end
    endtask

    // Monitor: pops the scoreboard on every ack, otherwise checks err low and rdata held
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 3; k++) begin
                if (ack[k]) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack dut%0d: got ack=1, required ack=0 at cycle %0d", k, cyc);
                    end else begin
                        mx = sb[k].pop_front();
                        chk("ack_cycle", k, cyc, mx.c);
                        chk("err", k, 32'(err[k]), 32'(mx.e));
                        chk("rdata", k, rdata[k], mx.d);
                        shown[k] = mx.d;
                    end
                end else begin
                    chk("err_without_ack", k, 32'(err[k]), 32'd0);
                    chk("rdata_hold", k, rdata[k], shown[k]);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  ix;
        int          k;
        int          r;
        for (int i = 0; i < 3; i++) begin
            rs[i]    = 1'b1;
            req[i]   = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
            be[i]    = '0;
            last[i]  = '0;
            shown[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ack", i, 32'(ack[i]), 32'd0);
            chk("reset_busy", i, 32'(busy[i]), 32'd0);
            chk("reset_err", i, 32'(err[i]), 32'd0);
            chk("reset_rdata", i, rdata[i], 32'd0);
            rs[i] = 1'b0;
        end
        mon_on = 1'b1;

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 256; j++)
                issue(i, 1'b1, 32'(j * 4), $urandom, 4'hF, 1'b0);

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0);
        issue(0, 1'b1, 32'h11, 32'hCAFEF00D, 4'hF, 1'b0);
        issue(0, 1'b1, 32'hFFFF_FFFC, 32'hCAFEF00D, 4'hF, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0);

        b2b(32'h10, 32'h20, 32'h3FC);

        issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        issue(1, 1'b1, 32'h40, 32'h89ABCDEF, 4'b1010, 1'b0);
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);

        issue(2, 1'b1, 32'h44, 32'h0BADC0DE, 4'hF, 1'b1);
        issue(2, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1);
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

        @(negedge clk);
        req[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h20;
        wdata[2] = 32'hA5A5A5A5;
        be[2]    = 4'hF;
        @(negedge clk);
        #1;
        chk("busy_in_wait", 2, 32'(busy[2]), 32'd1);
        rs[2]    = 1'b1;
        req[2]   = 1'b0;
        shown[2] = '0;
        last[2]  = '0;
        @(negedge clk);
        #1;
        chk("busy_after_abort", 2, 32'(busy[2]), 32'd0);
        chk("rdata_after_abort", 2, rdata[2], 32'd0);
        rs[2] = 1'b0;
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            k  = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            ix = 8'($urandom);
            a  = (r < 8) ? {22'd0, ix, 2'd0}
               : (r == 8) ? {22'd0, ix, 2'(1 + $urandom_range(0, 2))}
               : ($urandom | 32'h400);
            issue(k, 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
        end

        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("scoreboard_empty", i, 32'(sb[i].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words held.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: cycles from request accept to ack.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  initiator request; held high until ack.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  write data.
REQ-009 be  input  4  byte-lane enables; bit i enables wdata[8i+7:8i].
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  read data, valid in the ack cycle and held until the next ack.
REQ-012 busy  output  1  high from accept through the ack cycle.
REQ-013 err  output  1  error flag, qualified by ack.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL capture we/addr/wdata/be, set busy=1, and go to WAIT (LATENCY>1, counter=LATENCY-2) or to RESP (LATENCY=1).
REQ-016 WAIT SHALL decrement the counter and enter RESP the cycle after it reads zero.
REQ-017 A request sampled in IDLE at cycle N SHALL produce ack=1 at cycle N+LATENCY, for exactly one cycle.
REQ-018 RESP SHALL always return to IDLE the next cycle; busy SHALL deassert in that IDLE cycle.
REQ-019 req, we, addr, wdata and be SHALL be ignored outside IDLE; only captured values are used.
REQ-020 If req is still high in the IDLE cycle after ack, it SHALL be accepted as a new transaction (back-to-back period = LATENCY+1).
REQ-021 A read SHALL return word addr[log2(DEPTH)+1:2] into rdata in the ack cycle; rdata SHALL be unchanged otherwise.
REQ-022 A write SHALL update only the enabled byte lanes, committed on the RESP edge; rdata SHALL be unchanged on writes.
REQ-023 be=0000 on a write SHALL complete normally with no storage change.
REQ-024 An error SHALL be raised when addr[1:0]!=0 or addr>=4*DEPTH; the block SHALL then perform no memory access, assert err=1 with ack, and set rdata=0 (reads and writes alike).
REQ-025 err SHALL be 0 whenever ack=0.
REQ-026 A read following a write to the same word SHALL return the written data.

Reset
REQ-027 reset=1 SHALL force state=IDLE, ack=0, busy=0, err=0 and rdata=0 at the next edge.
REQ-028 reset SHALL take priority over all other inputs, and reset during WAIT/RESP SHALL abort the transaction with no write and no ack.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 Shared package cpu_mem_pkg SHALL hold the state enum, WORD_W=32 and BE_W=4.
REQ-031 Storage SHALL be one sub-module, mem_array: synchronous byte-enabled write, combinational read, parameter DEPTH.
REQ-032 The FSM, counter, capture registers and error decode SHALL reside in data_mem_responder.

Verification
REQ-033 Reset, then write addr=0x10, wdata=0xDEADBEEF, be=1111 (LATENCY=2) -> ack at accept+2, err=0; read 0x10 -> rdata=0xDEADBEEF at accept+2.
REQ-034 Write 0x10, wdata=0x11223344, be=0101 over 0xDEADBEEF -> subsequent read of 0x10 returns 0xDE22BE44.
REQ-035 Read addr=0x13 -> ack with err=1 and rdata=0; read addr=0x400 (DEPTH=256) -> err=1; memory unchanged.
REQ-036 Hold req=1 across three reads -> acks spaced 3 cycles apart, busy low exactly one cycle between them.
REQ-037 Assert reset during WAIT of a write to 0x20 -> no ack; busy=0 next cycle; a later read of 0x20 returns the prior value.
REQ-038 LATENCY=1: read accepted at cycle N -> ack at N+1; toggle we/addr during WAIT (LATENCY=4) -> response reflects the captured values.
